// File: rtl/hazard_stall_unit.sv
// Stall/flush controller beside ID: load-use, mult/div HI/LO occupancy,
// taken-branch flush, plus a saturating stall-cycle counter.
module hazard_stall_unit #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ID_RsAddr,
  input  logic [4:0]       ID_RtAddr,
  input  logic             ID_UsesRs,
  input  logic             ID_UsesRt,
  input  logic             ID_IsMD,
  input  logic             ID_ReadsHiLo,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_wAddr,
  input  logic             EX_BranchTaken,
  output logic             Stall,
  output logic             Bubble,
  output logic             Flush_IFID,
  output logic             MD_Busy,
  output logic [CNT_W-1:0] StallCnt
);

  localparam int MdW = $clog2(MD_LATENCY + 1);
  localparam logic [MdW-1:0] MdLoad = MdW'(MD_LATENCY);

  typedef enum logic {
    MD_IDLE,
    MD_RUN
  } mdState_t;

  mdState_t       mdState;
  mdState_t       mdStateNxt;
  logic [MdW-1:0] mdCnt;
  logic [MdW-1:0] mdCntNxt;

  logic loadUse;
  logic mdHazard;
  logic mdIssue;
  logic rsHit;
  logic rtHit;
  logic stallRaw;
  logic bubbleRaw;
  logic flushRaw;

  assign rsHit = ID_UsesRs & (EX_wAddr == ID_RsAddr);
  assign rtHit = ID_UsesRt & (EX_wAddr == ID_RtAddr);

  assign loadUse = EX_MemRead
                 & (EX_wAddr != 5'd0)
                 & (rsHit | rtHit);

  assign MD_Busy  = rst_n & (mdCnt != '0);
  assign mdHazard = MD_Busy & (ID_IsMD | ID_ReadsHiLo);

  always_comb begin
    stallRaw  = 1'b0;
    bubbleRaw = 1'b0;
    flushRaw  = 1'b0;
    unique case (1'b1)
      EX_BranchTaken: begin
        flushRaw  = 1'b1;
        bubbleRaw = 1'b1;
      end
      (~EX_BranchTaken & (loadUse | mdHazard)): begin
        stallRaw  = 1'b1;
        bubbleRaw = 1'b1;
      end
      default: ;
    endcase
  end

  // Outputs drop the instant reset asserts, independent of ID/EX inputs.
  assign Stall      = rst_n & stallRaw;
  assign Bubble     = rst_n & bubbleRaw;
  assign Flush_IFID = rst_n & flushRaw;

  assign mdIssue = ID_IsMD & ~Stall & ~EX_BranchTaken;

  always_comb begin
    mdStateNxt = mdState;
    mdCntNxt   = mdCnt;
    unique case (mdState)
      MD_IDLE: begin
        if (mdIssue) begin
          mdCntNxt   = MdLoad;
          mdStateNxt = MD_RUN;
        end
      end
      MD_RUN: begin
        // A committed op keeps counting through stalls and flushes.
        mdCntNxt = mdCnt - MdW'(1);
        if (mdCnt == MdW'(1)) begin
          mdStateNxt = MD_IDLE;
        end
      end
      default: begin
        mdStateNxt = MD_IDLE;
        mdCntNxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdState <= MD_IDLE;
      mdCnt   <= '0;
    end else begin
      mdState <= mdStateNxt;
      mdCnt   <= mdCntNxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCnt <= '0;
    end else if (Stall && (StallCnt != '1)) begin
      StallCnt <= StallCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: inputs driven after negedge,
// outputs checked 1ns later, state updates on the following posedge.
module tb_hazard_stall_unit;

  logic        clk;
  logic        rst_n;
  logic [4:0]  ID_RsAddr;
  logic [4:0]  ID_RtAddr;
  logic        ID_UsesRs;
  logic        ID_UsesRt;
  logic        ID_IsMD;
  logic        ID_ReadsHiLo;
  logic        EX_MemRead;
  logic [4:0]  EX_wAddr;
  logic        EX_BranchTaken;
  logic        Stall;
  logic        Bubble;
  logic        Flush_IFID;
  logic        MD_Busy;
  logic [15:0] StallCnt;

  int vectors = 0;
  int miscompares = 0;

  hazard_stall_unit #(
    .MD_LATENCY(4),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ID_RsAddr(ID_RsAddr),
    .ID_RtAddr(ID_RtAddr),
    .ID_UsesRs(ID_UsesRs),
    .ID_UsesRt(ID_UsesRt),
    .ID_IsMD(ID_IsMD),
    .ID_ReadsHiLo(ID_ReadsHiLo),
    .EX_MemRead(EX_MemRead),
    .EX_wAddr(EX_wAddr),
    .EX_BranchTaken(EX_BranchTaken),
    .Stall(Stall),
    .Bubble(Bubble),
    .Flush_IFID(Flush_IFID),
    .MD_Busy(MD_Busy),
    .StallCnt(StallCnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkCnt(input string tag, input logic [15:0] exp);
    vectors++;
    assert (StallCnt === exp) else begin
      miscompares++;
      $error("FAIL %s.cnt: observed %0h expected %0h", tag, StallCnt, exp);
    end
  endtask

  task automatic outs(input string tag, input logic s, input logic b,
                      input logic f, input logic m);
    chk1({tag, ".stall"}, Stall, s);
    chk1({tag, ".bubble"}, Bubble, b);
    chk1({tag, ".flush"}, Flush_IFID, f);
    chk1({tag, ".busy"}, MD_Busy, m);
  endtask

  task automatic clr();
    ID_RsAddr      = 5'd0;
    ID_RtAddr      = 5'd0;
    ID_UsesRs      = 1'b0;
    ID_UsesRt      = 1'b0;
    ID_IsMD        = 1'b0;
    ID_ReadsHiLo   = 1'b0;
    EX_MemRead     = 1'b0;
    EX_wAddr       = 5'd0;
    EX_BranchTaken = 1'b0;
  endtask

  task automatic loadUse5();
    EX_MemRead = 1'b1;
    EX_wAddr   = 5'd5;
    ID_RsAddr  = 5'd5;
    ID_UsesRs  = 1'b1;
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    loadUse5();
    #1;
    outs("rst", 0, 0, 0, 0);
    chkCnt("rst", 16'd0);

    @(negedge clk);
    rst_n = 1'b1;
    clr();
    #1;
    outs("idle", 0, 0, 0, 0);

    // load-use through rs
    @(negedge clk);
    loadUse5();
    #1;
    outs("lu_rs", 1, 1, 0, 0);
    chkCnt("lu_rs", 16'd0);
    @(negedge clk);
    clr();
    #1;
    outs("lu_rs_clear", 0, 0, 0, 0);
    chkCnt("lu_rs_clear", 16'd1);

    // load-use through rt, then same match with rt unused
    @(negedge clk);
    EX_MemRead = 1'b1;
    EX_wAddr   = 5'd7;
    ID_RtAddr  = 5'd7;
    ID_RsAddr  = 5'd7;
    ID_UsesRt  = 1'b1;
    #1;
    outs("lu_rt", 1, 1, 0, 0);
    @(negedge clk);
    ID_UsesRt = 1'b0;
    #1;
    outs("lu_rt_unused", 0, 0, 0, 0);
    chkCnt("lu_rt", 16'd2);

    // register 0 never hazards
    @(negedge clk);
    clr();
    EX_MemRead = 1'b1;
    ID_UsesRs  = 1'b1;
    ID_UsesRt  = 1'b1;
    #1;
    outs("lu_r0", 0, 0, 0, 0);

    // mult issue, mflo stalls 4 cycles
    @(negedge clk);
    clr();
    ID_IsMD = 1'b1;
    #1;
    outs("mult_issue", 0, 0, 0, 0);
    @(negedge clk);
    clr();
    ID_ReadsHiLo = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      outs($sformatf("mflo_wait%0d", i), 1, 1, 0, 1);
      @(negedge clk);
    end
    #1;
    outs("mflo_go", 0, 0, 0, 0);
    chkCnt("mflo_go", 16'd6);

    // back-to-back mult: second waits, then issues at count 0
    @(negedge clk);
    clr();
    ID_IsMD = 1'b1;
    #1;
    outs("mult1", 0, 0, 0, 0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      #1;
      outs($sformatf("mult2_wait%0d", i), 1, 1, 0, 1);
      @(negedge clk);
    end
    #1;
    outs("mult2_issue", 0, 0, 0, 0);
    chkCnt("mult2_issue", 16'd10);

    // load-use and md hazard together count once
    @(negedge clk);
    clr();
    ID_ReadsHiLo = 1'b1;
    EX_MemRead   = 1'b1;
    EX_wAddr     = 5'd3;
    ID_RsAddr    = 5'd3;
    ID_UsesRs    = 1'b1;
    #1;
    outs("both_hz", 1, 1, 0, 1);
    @(negedge clk);
    clr();
    #1;
    outs("both_after", 0, 0, 0, 1);
    chkCnt("both_after", 16'd11);
    repeat (3) @(negedge clk);
    #1;
    outs("mult2_done", 0, 0, 0, 0);

    // branch beats load-use
    @(negedge clk);
    loadUse5();
    EX_BranchTaken = 1'b1;
    #1;
    outs("br_lu", 0, 1, 1, 0);
    @(negedge clk);
    clr();
    #1;
    chkCnt("br_lu", 16'd11);

    // mult under taken branch does not issue
    @(negedge clk);
    ID_IsMD        = 1'b1;
    EX_BranchTaken = 1'b1;
    #1;
    outs("br_mult", 0, 1, 1, 0);
    @(negedge clk);
    clr();
    #1;
    outs("br_mult_after", 0, 0, 0, 0);

    // branch during MD_RUN keeps counting, then reset at count 2
    @(negedge clk);
    ID_IsMD = 1'b1;
    #1;
    outs("mult3", 0, 0, 0, 0);
    @(negedge clk);
    clr();
    EX_BranchTaken = 1'b1;
    ID_ReadsHiLo   = 1'b1;
    #1;
    outs("br_busy", 0, 1, 1, 1);
    @(negedge clk);
    EX_BranchTaken = 1'b0;
    #1;
    outs("cnt3", 1, 1, 0, 1);
    @(negedge clk);
    #1;
    outs("cnt2", 1, 1, 0, 1);
    chkCnt("cnt2", 16'd12);
    #1;
    rst_n = 1'b0;
    #1;
    outs("mid_rst", 0, 0, 0, 0);
    chkCnt("mid_rst", 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    outs("post_rst_mflo", 0, 0, 0, 0);

    // saturation
    @(negedge clk);
    clr();
    loadUse5();
    #1;
    outs("sat_start", 1, 1, 0, 0);
    chkCnt("sat_start", 16'd0);
    repeat ((1 << 16) + 3) @(negedge clk);
    #1;
    outs("sat_hold", 1, 1, 0, 0);
    chkCnt("sat", 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
